decode_queue: RTL and testbench
===============================

Name: decode_queue

Overview:
- Registered, parametrised RV32I/RV64I instruction decode stage with a DEPTH-entry output queue.
- Sits between fetch and execute.
- Accepts raw instruction words plus PC over a valid/ready handshake and decodes opcode, register fields, format and the selected immediate.
- Buffers decoded results so fetch is decoupled from execute stalls; supports pipeline flush on redirect.

Parameters:
- XLEN, 32, datapath width; 32 or 64; sets immediate and PC width.
- ILEN, 32, instruction width; fixed at 32.
- DEPTH, 2, queue entries; power of two, 2..16.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  synchronous active-low reset.
- flush  in  1  discard all queued entries and any same-cycle input.
- in_valid  in  1  instruction word present.
- in_ready  out  1  queue can accept this cycle.
- in_instr  in  ILEN  raw instruction bits.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head this cycle.
- out_pc  out  XLEN  PC of head.
- out_opcode  out  7  instr[6:0].
- out_rd  out  5  instr[11:7].
- out_rs1  out  5  instr[19:15].
- out_rs2  out  5  instr[24:20].
- out_funct3  out  3  instr[14:12].
- out_funct7  out  7  instr[31:25].
- out_fmt  out  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=illegal.
- out_imm  out  XLEN  immediate for out_fmt, sign-extended to XLEN.
- out_illegal  out  1  opcode unrecognised or instr[1:0]!=2'b11.
- occupancy  out  $clog2(DEPTH)+1  entries held.

Behaviour:
- Format by opcode:
  - 0110111, 0010111 -> U.
  - 1101111 -> J.
  - 1100111, 0000011, 0010011, 0001111, 1110011 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110011 -> R.
  - Anything else, or instr[1:0]!=11 -> fmt 6, illegal=1.
- Immediates (bit 31 is the sign):
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0} (13 bits).
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0} (21 bits).
  - U = {instr[31:12], 12'b0}.
  - All sign-extended from their MSB to XLEN; U also sign-extends bit 31 when XLEN=64.
  - R and illegal -> imm=0.
- Field outputs (rd/rs1/rs2/funct3/funct7) are always raw slices, regardless of format.
- Decode is combinational on input; decoded record is written into the queue at the accepting edge.
- All out_* are driven from registered queue storage, with no combinational path from in_* to out_*.
- Push when in_valid && in_ready && !flush.
- Pop when out_valid && out_ready.
- in_ready = (occupancy < DEPTH); no bypass when full, even if a pop occurs the same cycle.
- Latency: instruction accepted at edge N appears at head (out_valid=1) after edge N, if the queue was empty.
- Simultaneous push and pop when not full: occupancy unchanged; order preserved.
- Strict FIFO order; read/write pointers wrap modulo DEPTH.
- out_valid = (occupancy != 0).
- Head payload is held stable while out_valid && !out_ready.
- Flush: at the next edge occupancy=0 and pointers=0; the same-cycle push is dropped and the same-cycle pop is irrelevant. in_ready=1 the cycle after.
- Reset (reset_n=0 at edge):
  - occupancy=0, pointers=0, out_valid=0.
  - Head payload reads 0 (fmt=0, illegal=0).
  - Reset wins over flush/push/pop; mid-stream reset discards everything.
- Payload outputs when out_valid=0 are don't-care after reset, but must not be X in simulation.
- Assertions:
  - No push when full.
  - No pop when empty.
  - occupancy <= DEPTH.

Test Plan:
- Reset then push 0x00500093 (addi x1,x0,5) at pc 0x100 -> after one edge: out_valid=1, fmt=1, rd=1, rs1=0, imm=5, pc=0x100, illegal=0.
- Immediate extraction:
  - 0xFE000EE3 (beq x0,x0,-4) -> fmt=3, imm=0xFFFFFFFC.
  - 0x800000EF (jal, min offset) -> fmt=5, imm=0xFFF00000.
  - 0xDEADB0B7 (lui x1) -> fmt=4, imm=0xDEADB000; with XLEN=64, imm=0xFFFFFFFFDEADB000.
- Illegal cases:
  - 0x0000007F -> fmt=6, illegal=1, imm=0.
  - 0x00000000 -> illegal=1.
  - R-type 0x40208033 (sub x0,x1,x2) -> fmt=0, rs2=2, funct7=0x20, imm=0.
- Backpressure with DEPTH=2, out_ready=0, push three instructions -> in_ready=0 after second accept, occupancy=2, head unchanged. Raise out_ready -> order A, B, C preserved.
- Full throughput: continuous in_valid/out_ready=1 for 100 instructions -> one output per cycle, occupancy stays 1, no loss or duplication.
- Flush with occupancy=2 and in_valid=1 the same cycle -> next cycle occupancy=0, out_valid=0, flushed input never appears. Reset_n=0 mid-stream -> same empty state.

Source files
------------

// File: rtl/decode_queue.sv
// RV32I/RV64I decode stage: decodes fetch words combinationally and buffers the
// decoded records in a DEPTH-entry FIFO so execute stalls do not back up fetch.
module decode_queue #(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ILEN-1:0]            in_instr,
  input  logic [XLEN-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [6:0]                 out_opcode,
  output logic [4:0]                 out_rd,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [2:0]                 out_funct3,
  output logic [6:0]                 out_funct7,
  output logic [2:0]                 out_fmt,
  output logic [XLEN-1:0]            out_imm,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam logic [OW-1:0] DEPTH_OCC = OW'(DEPTH);

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd6
  } fmt_e;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_FENCE  = 7'b0001111,
    OP_SYSTEM = 7'b1110011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_REG    = 7'b0110011
  } opcode_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    fmt_e            fmt;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } entry_t;

  entry_t          dec;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]   occ_q, occ_d;
  logic            push, pop;
  entry_t          head;

  // Signed casts replicate instr[31] up to XLEN, covering U on RV64 as well.
  always_comb begin
    imm_i = XLEN'($signed(in_instr[31:20]));
    imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
    imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                           in_instr[11:8], 1'b0}));
    imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                           in_instr[30:21], 1'b0}));
    imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
  end

  always_comb begin
    dec         = '0;
    dec.pc      = in_pc;
    dec.opcode  = in_instr[6:0];
    dec.rd      = in_instr[11:7];
    dec.rs1     = in_instr[19:15];
    dec.rs2     = in_instr[24:20];
    dec.funct3  = in_instr[14:12];
    dec.funct7  = in_instr[31:25];
    dec.fmt     = FMT_ILL;
    dec.imm     = '0;
    dec.illegal = 1'b1;
    if (in_instr[1:0] == 2'b11) begin
      dec.illegal = 1'b0;
      case (in_instr[6:0])
        OP_LUI, OP_AUIPC: begin
          dec.fmt = FMT_U;
          dec.imm = imm_u;
        end
        OP_JAL: begin
          dec.fmt = FMT_J;
          dec.imm = imm_j;
        end
        OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM: begin
          dec.fmt = FMT_I;
          dec.imm = imm_i;
        end
        OP_STORE: begin
          dec.fmt = FMT_S;
          dec.imm = imm_s;
        end
        OP_BRANCH: begin
          dec.fmt = FMT_B;
          dec.imm = imm_b;
        end
        OP_REG: begin
          dec.fmt = FMT_R;
        end
        default: begin
          dec.fmt     = FMT_ILL;
          dec.illegal = 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = (occ_q < DEPTH_OCC);
  assign out_valid = (occ_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = dec;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + OW'(1);
        2'b01:   occ_d = occ_q - OW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads as zeros rather than X.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign out_pc      = head.pc;
  assign out_opcode  = head.opcode;
  assign out_rd      = head.rd;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_funct3  = head.funct3;
  assign out_funct7  = head.funct7;
  assign out_fmt     = head.fmt;
  assign out_imm     = head.imm;
  assign out_illegal = head.illegal;
  assign occupancy   = occ_q;

  a_no_push_full: assert property (@(posedge clk) disable iff (!reset_n)
    push |-> (occ_q != DEPTH_OCC));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset_n)
    pop |-> (occ_q != '0));
  a_occ_bound: assert property (@(posedge clk) disable iff (!reset_n)
    occ_q <= DEPTH_OCC);

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: stimulus pushes expected records on accept,
// a negedge monitor pops and compares them on every output handshake.
module tb_decode_queue;

  logic        clk = 1'b0;
  logic        reset_n, flush, in_valid, out_ready;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [6:0]  out_opcode, out_funct7;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3, out_fmt;
  logic [1:0]  occupancy;

  logic        flush64, in64_valid, in64_ready, out64_valid, out64_ready, out64_illegal;
  logic [31:0] in64_instr;
  logic [63:0] in64_pc, out64_pc, out64_imm;
  logic [6:0]  out64_opcode, out64_funct7;
  logic [4:0]  out64_rd, out64_rs1, out64_rs2;
  logic [2:0]  out64_funct3, out64_fmt;
  logic [1:0]  occupancy64;

  always #5 clk = ~clk;

  decode_queue #(.XLEN(32), .ILEN(32), .DEPTH(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_fmt(out_fmt),
    .out_imm(out_imm), .out_illegal(out_illegal), .occupancy(occupancy)
  );

  decode_queue #(.XLEN(64), .ILEN(32), .DEPTH(2)) u_dut64 (
    .clk(clk), .reset_n(reset_n), .flush(flush64),
    .in_valid(in64_valid), .in_ready(in64_ready), .in_instr(in64_instr), .in_pc(in64_pc),
    .out_valid(out64_valid), .out_ready(out64_ready), .out_pc(out64_pc),
    .out_opcode(out64_opcode), .out_rd(out64_rd), .out_rs1(out64_rs1), .out_rs2(out64_rs2),
    .out_funct3(out64_funct3), .out_funct7(out64_funct7), .out_fmt(out64_fmt),
    .out_imm(out64_imm), .out_illegal(out64_illegal), .occupancy(occupancy64)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   n_err = 0;
  int   n_chk = 0;
  int   n_pop = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Field expectations are the raw bit slices of the instruction word.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_output: actual pc=0x%0h required=no output", out_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_pop++;
        chk("pc",      64'(out_pc),      64'(e.pc));
        chk("opcode",  64'(out_opcode),  64'(e.instr[6:0]));
        chk("rd",      64'(out_rd),      64'(e.instr[11:7]));
        chk("rs1",     64'(out_rs1),     64'(e.instr[19:15]));
        chk("rs2",     64'(out_rs2),     64'(e.instr[24:20]));
        chk("funct3",  64'(out_funct3),  64'(e.instr[14:12]));
        chk("funct7",  64'(out_funct7),  64'(e.instr[31:25]));
        chk("fmt",     64'(out_fmt),     64'(e.fmt));
        chk("imm",     64'(out_imm),     64'(e.imm));
        chk("illegal", 64'(out_illegal), 64'(e.ill));
      end
    end
  end

  task automatic push_instr(input logic [31:0] ins, input logic [31:0] pc,
                            input logic [2:0] fmt, input logic [31:0] imm, input logic ill);
    int   waited;
    exp_t e;
    waited   = 0;
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_chk++;
      n_err++;
      $display("FAIL push_timeout: in_ready=0 required=1 pc=0x%0h", pc);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.pc = pc; e.instr = ins; e.fmt = fmt; e.imm = imm; e.ill = ill;
    sb.push_back(e);
    #1;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (sb.size() != 0 && waited < 40) begin
      waited++;
      @(negedge clk);
    end
    chk("drain_remaining", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_empty(input string tag);
    chk({tag, "_occupancy"}, 64'(occupancy), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
  endtask

  logic [31:0] t_instr [12] = '{32'hFE000EE3, 32'h800000EF, 32'hDEADB0B7, 32'hFE112E23,
                                32'h7FF00003, 32'h0000007F, 32'h00000000, 32'h40208033,
                                32'h00500091, 32'h12345097, 32'h00000073, 32'h00500093};
  logic [2:0]  t_fmt   [12] = '{3'd3, 3'd5, 3'd4, 3'd2, 3'd1, 3'd6, 3'd6, 3'd0,
                                3'd6, 3'd4, 3'd1, 3'd1};
  logic [31:0] t_imm   [12] = '{32'hFFFFFFFC, 32'hFFF00000, 32'hDEADB000, 32'hFFFFFFFC,
                                32'h000007FF, 32'h0, 32'h0, 32'h0,
                                32'h0, 32'h12345000, 32'h0, 32'h5};
  logic        t_ill   [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                                1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops0, cyc0;
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    flush64 = 1'b0; in64_valid = 1'b0; out64_ready = 1'b0;
    in64_instr = '0; in64_pc = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check_empty("reset");
    chk("reset_pc",      64'(out_pc),      64'd0);
    chk("reset_fmt",     64'(out_fmt),     64'd0);
    chk("reset_imm",     64'(out_imm),     64'd0);
    chk("reset_illegal", 64'(out_illegal), 64'd0);
    @(posedge clk);
    #1;

    // addi x1,x0,5: visible at the head right after the accepting edge
    push_instr(32'h00500093, 32'h100, 3'd1, 32'h5, 1'b0);
    in_valid = 1'b0;
    chk("lat_out_valid", 64'(out_valid), 64'd1);
    chk("lat_occupancy", 64'(occupancy), 64'd1);
    chk("lat_rd",        64'(out_rd),    64'd1);
    chk("lat_imm",       64'(out_imm),   64'd5);
    out_ready = 1'b1;
    drain();

    for (int i = 0; i < 12; i++) begin
      push_instr(t_instr[i], 32'h200 + 32'(4 * i), t_fmt[i], t_imm[i], t_ill[i]);
    end
    in_valid = 1'b0;
    drain();

    // Backpressure: A and B fill the queue, C waits until the consumer resumes.
    out_ready = 1'b0;
    push_instr(32'h00100093, 32'h300, 3'd1, 32'h1, 1'b0);
    push_instr(32'h00200113, 32'h304, 3'd1, 32'h2, 1'b0);
    in_instr = 32'h00300193;
    in_pc    = 32'h308;
    @(negedge clk);
    chk("bp_in_ready",  64'(in_ready),  64'd0);
    chk("bp_occupancy", 64'(occupancy), 64'd2);
    chk("bp_head_pc",   64'(out_pc),    64'h300);
    @(negedge clk);
    chk("bp_head_hold", 64'(out_pc),    64'h300);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    push_instr(32'h00300193, 32'h308, 3'd1, 32'h3, 1'b0);
    in_valid = 1'b0;
    drain();

    pops0 = n_pop;
    cyc0  = cyc;
    for (int i = 0; i < 100; i++) begin
      push_instr({12'(i), 20'h00013}, 32'h1000 + 32'(4 * i), 3'd1, 32'(i), 1'b0);
      chk("thru_occupancy", 64'(occupancy), 64'd1);
    end
    chk("thru_cycles", 64'(cyc - cyc0), 64'd100);
    in_valid = 1'b0;
    drain();
    chk("thru_pops", 64'(n_pop - pops0), 64'd100);

    // Flush while full with a pending input.
    out_ready = 1'b0;
    push_instr(32'h00500093, 32'h400, 3'd1, 32'h5, 1'b0);
    push_instr(32'h00600093, 32'h404, 3'd1, 32'h6, 1'b0);
    in_instr = 32'h00700393; in_pc = 32'h408; flush = 1'b1;
    @(posedge clk);
    sb.delete();
    #1 flush = 1'b0; in_valid = 1'b0;
    check_empty("flush_full");
    // Flush with room: the same-cycle input would otherwise be accepted.
    push_instr(32'h00800093, 32'h500, 3'd1, 32'h8, 1'b0);
    in_instr = 32'h00900093; in_pc = 32'h504; flush = 1'b1;
    @(posedge clk);
    sb.delete();
    #1 flush = 1'b0; in_valid = 1'b0;
    check_empty("flush_part");
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    push_instr(32'h00A00093, 32'h600, 3'd1, 32'hA, 1'b0);
    in_valid = 1'b0;
    drain();

    // Reset mid-stream discards queued entries.
    out_ready = 1'b0;
    push_instr(32'h00B00093, 32'h700, 3'd1, 32'hB, 1'b0);
    push_instr(32'h00C00093, 32'h704, 3'd1, 32'hC, 1'b0);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    @(posedge clk);
    sb.delete();
    #1 reset_n = 1'b1;
    check_empty("midreset");
    chk("midreset_pc",  64'(out_pc),  64'd0);
    chk("midreset_imm", 64'(out_imm), 64'd0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // RV64: lui sign-extends bit 31 into the upper word.
    in64_valid = 1'b1;
    in64_instr = 32'hDEADB0B7;
    in64_pc    = 64'h8000_0000_0000_0010;
    @(negedge clk);
    chk("x64_in_ready", 64'(in64_ready), 64'd1);
    @(posedge clk);
    #1 in64_valid = 1'b0;
    chk("x64_out_valid", 64'(out64_valid), 64'd1);
    chk("x64_fmt",       64'(out64_fmt),   64'd4);
    chk("x64_imm",       out64_imm,        64'hFFFF_FFFF_DEAD_B000);
    chk("x64_pc",        out64_pc,         64'h8000_0000_0000_0010);
    chk("x64_rd",        64'(out64_rd),    64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
